// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one 32-bit ALU between two requesters. Arbitration is
// round-robin. Accepted operands and the op code are held in registers
// that drive the ALU. MUL is held for MUL_CYCLES cycles. The result and
// zero flag go back to the owner as a one-cycle response pulse.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o       request handshake, N = 0,1
//   reqN_a_i, reqN_b_i, reqN_op_i     request operands and op code
//   resp0_valid_o, resp1_valid_o      one-cycle response pulse per requester
//   resp_data_o, resp_zero_o          result and zero flag (held until next capture)
//   alu_data0_o, alu_data1_o, alu_ctrl_o   registered ALU drive
//   alu_data_i, alu_zero_i            ALU result and zero flag
//   busy_o                            high while an operation executes
module alu_share_arbiter #(
    parameter int MUL_CYCLES = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [2:0]       req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [2:0]       req1_op_i,
    output logic             resp0_valid_o,
    output logic             resp1_valid_o,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_zero_o,
    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    localparam logic [2:0] OP_MUL   = 3'b010;
    // The count is loaded on the transfer edge, so MUL holds EXEC for
    // MUL_CYCLES cycles when it counts down to zero before capturing.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_zero_q, resp_zero_d;

    logic             any_valid_s;
    logic             grant_id_s;
    logic             xfer_s;

    assign any_valid_s = req0_valid_i | req1_valid_i;
    assign xfer_s      = (state_q == IDLE) && any_valid_s;

    // Round-robin grant: when both requesters are valid, the one that did not win last time wins.
    always_comb begin
        grant_id_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_id_s = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    assign req0_ready_o = xfer_s && (grant_id_s == 1'b0);
    assign req1_ready_o = xfer_s && (grant_id_s == 1'b1);

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        resp_data_d   = resp_data_q;
        resp_zero_d   = resp_zero_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    owner_d      = grant_id_s;
                    last_grant_d = grant_id_s;
                    a_d          = grant_id_s ? req1_a_i  : req0_a_i;
                    b_d          = grant_id_s ? req1_b_i  : req0_b_i;
                    op_d         = grant_id_s ? req1_op_i : req0_op_i;
                    cnt_d        = ((grant_id_s ? req1_op_i : req0_op_i) == OP_MUL) ? MUL_LOAD : 4'd0;
                    state_d      = EXEC;
                end else begin
                    state_d      = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_data_d   = alu_data_i;
                    resp_zero_d   = alu_zero_i;
                    resp0_valid_d = ~owner_q;
                    resp1_valid_d = owner_q;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight op and restores requester 0 priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 3'b000;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp_data_q   <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp_data_q   <= resp_data_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    assign alu_data0_o   = a_q;
    assign alu_data1_o   = b_q;
    assign alu_ctrl_o    = op_q;
    assign resp0_valid_o = resp0_valid_q;
    assign resp1_valid_o = resp1_valid_q;
    assign resp_data_o   = resp_data_q;
    assign resp_zero_o   = resp_zero_q;
    assign busy_o        = (state_q == EXEC);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios followed by random
// single and contended requests, checked against a reference model.
module tb_alu_share_arbiter;

    localparam int MUL_C = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o;
    logic [31:0] req0_a_i, req0_b_i;
    logic [2:0]  req0_op_i;
    logic        req1_valid_i, req1_ready_o;
    logic [31:0] req1_a_i, req1_b_i;
    logic [2:0]  req1_op_i;
    logic        resp0_valid_o, resp1_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_zero_o;
    logic [31:0] alu_data0_o, alu_data1_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;
    logic        busy_o;

    int vectors    = 0;
    int miscompares = 0;
    int lg         = 1;   // model of the last granted requester

    alu_share_arbiter #(.MUL_CYCLES(MUL_C), .WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
        .resp0_valid_o(resp0_valid_o), .resp1_valid_o(resp1_valid_o),
        .resp_data_o(resp_data_o), .resp_zero_o(resp_zero_o),
        .alu_data0_o(alu_data0_o), .alu_data1_o(alu_data1_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference arithmetic for an op code; invalid codes yield 0.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a * b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU attached to the DUT's ALU drive.
    assign alu_data_i = ref_alu(alu_data0_o, alu_data1_o, alu_ctrl_o);
    assign alu_zero_i = (alu_data_i == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int who, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (who == 0) begin
            req0_valid_i = v; req0_a_i = a; req0_b_i = b; req0_op_i = op;
        end else begin
            req1_valid_i = v; req1_a_i = a; req1_b_i = b; req1_op_i = op;
        end
    endtask

    // Present a request, wait (bounded) for ready, transfer, then scramble the inputs.
    task automatic send(input int who, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int n = 0;
        drive(who, 1'b1, a, b, op);
        #1;
        while (!((who == 0) ? req0_ready_o : req1_ready_o) && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait_bound", 32'(n < 20), 32'd1);
        chk("ready_exclusive", 32'(req0_ready_o & req1_ready_o), 32'd0);
        tick();
        drive(who, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
        lg = who;
    endtask

    // From the cycle after a transfer, wait for the response pulse and check it.
    task automatic wait_resp(input int who, input logic [31:0] exp_d, input logic exp_z, input int exp_lat);
        int n = 0;
        int busy_n = 0;
        while (!(resp0_valid_o | resp1_valid_o) && n < 40) begin
            if (busy_o) begin
                busy_n++;
                chk("ready_in_exec", 32'({req0_ready_o, req1_ready_o}), 32'd0);
            end
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
        chk("resp_owner", 32'({resp1_valid_o, resp0_valid_o}), (who == 0) ? 32'd1 : 32'd2);
        chk("resp_data", resp_data_o, exp_d);
        chk("resp_zero", 32'(resp_zero_o), 32'(exp_z));
        chk("busy_at_resp", 32'(busy_o), 32'd0);
    endtask

    task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] r;
        r = ref_alu(a, b, op);
        send(who, a, b, op);
        wait_resp(who, r, (r == 32'd0), (op == 3'b010) ? MUL_C : 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int grants;
        int eg;
        int w;
        logic [31:0] ra, rb, la, lb;
        logic [2:0]  rop, lop;

        rst_i = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
        drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
        repeat (2) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        chk("rst_resp_valid", 32'({resp0_valid_o, resp1_valid_o}), 32'd0);
        chk("rst_resp_data", resp_data_o, 32'd0);
        chk("rst_resp_zero", 32'(resp_zero_o), 32'd0);
        chk("rst_alu0", alu_data0_o, 32'd0);
        chk("rst_alu1", alu_data1_o, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single ADD from requester 0, then the pulse must drop and data hold.
        do_op(0, 32'd5, 32'd7, 3'b000);
        tick();
        chk("pulse_width", 32'({resp0_valid_o, resp1_valid_o}), 32'd0);
        chk("resp_hold", resp_data_o, 32'd12);

        // Both requesters valid continuously after reset: alternating grants.
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick(); lg = 1;
        drive(0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b011);
        drive(1, 1'b1, 32'h00000001, 32'h00000002, 3'b100);
        #1;
        grants = 0;
        for (int c = 0; c < 9; c++) begin
            chk("rr_ready_exclusive", 32'(req0_ready_o & req1_ready_o), 32'd0);
            if (resp0_valid_o | resp1_valid_o) begin
                if (q.size() == 0) begin
                    chk("rr_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    eg = q.pop_front();
                    chk("rr_resp_owner", 32'({resp1_valid_o, resp0_valid_o}), (eg == 0) ? 32'd1 : 32'd2);
                    chk("rr_resp_data", resp_data_o, (eg == 0) ? 32'h0000F000 : 32'h00000003);
                end
            end
            if (c < 8) begin
                if (req0_ready_o | req1_ready_o) begin
                    eg = 1 - lg;
                    chk("rr_grant", 32'(req1_ready_o), 32'(eg));
                    q.push_back(eg);
                    lg = eg;
                    grants++;
                end
                tick();
            end
        end
        drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
        drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
        chk("rr_grant_count", 32'(grants), 32'd4);
        chk("rr_pending", 32'(q.size()), 32'd0);

        // MUL held for MUL_C cycles while requester 1 waits; it wins in the response cycle.
        tick();
        drive(1, 1'b1, 32'd1, 32'd2, 3'b100);
        drive(0, 1'b1, 32'd6, 32'd7, 3'b010);
        #1;
        chk("mul_arb", 32'({req0_ready_o, req1_ready_o}), 32'd2);
        send(0, 32'd6, 32'd7, 3'b010);
        wait_resp(0, 32'd42, 1'b0, MUL_C);
        chk("req1_granted_in_resp", 32'(req1_ready_o), 32'd1);
        send(1, 32'd1, 32'd2, 3'b100);
        wait_resp(1, 32'd3, 1'b0, 1);

        // Zero results, invalid op, wrap-around.
        do_op(0, 32'd9, 32'd9, 3'b001);
        do_op(0, 32'd3, 32'd4, 3'b111);
        do_op(1, 32'hFFFFFFFF, 32'd1, 3'b000);
        do_op(1, 32'hFFFFFFFF, 32'd2, 3'b010);
        tick();
        chk("idle_hold_ctrl", 32'(alu_ctrl_o), 32'd2);
        chk("idle_hold_a", alu_data0_o, 32'hFFFFFFFF);
        chk("idle_hold_b", alu_data1_o, 32'd2);
        chk("idle_hold_resp", resp_data_o, 32'hFFFFFFFE);

        // Reset in the second EXEC cycle of a MUL.
        send(0, 32'd3, 32'd5, 3'b010);
        tick();
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_resp_valid", 32'({resp0_valid_o, resp1_valid_o}), 32'd0);
        chk("midrst_resp_data", resp_data_o, 32'd0);
        chk("midrst_alu0", alu_data0_o, 32'd0);
        chk("midrst_alu1", alu_data1_o, 32'd0);
        chk("midrst_ctrl", 32'(alu_ctrl_o), 32'd0);
        tick();
        rst_i = 1'b0;
        lg = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("midrst_no_resp", 32'({resp0_valid_o, resp1_valid_o, busy_o}), 32'd0);
        end
        drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
        drive(1, 1'b1, 32'd9, 32'd9, 3'b001);
        #1;
        chk("midrst_priority", 32'({req0_ready_o, req1_ready_o}), 32'd2);
        drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
        do_op(0, 32'd1, 32'd1, 3'b000);

        // Random single and contended requests.
        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                la  = $urandom;
                lb  = ($urandom_range(0, 1) == 0) ? la : $urandom;
                lop = 3'($urandom_range(0, 7));
                w   = 1 - lg;
                drive(1 - w, 1'b1, la, lb, lop);
                drive(w, 1'b1, ra, rb, rop);
                #1;
                chk("rand_arb", 32'({req1_ready_o, req0_ready_o}), (w == 0) ? 32'd1 : 32'd2);
                do_op(w, ra, rb, rop);
                do_op(1 - w, la, lb, lop);
            end else begin
                do_op($urandom_range(0, 1), ra, rb, rop);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
